// File: rtl/sp_div_pkg.sv
// Shared types and constants for the single-precision divider front end.
package sp_div_pkg;

    // Exponent and mantissa widths of the unpacked operand form.
    localparam int EW = 10;
    localparam int MW = 24;

    localparam logic        [EW-1:0] BIAS = 10'd127;
    localparam logic signed [EW-1:0] EMIN = -10'sd126;
    localparam logic        [31:0]   QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNPACK = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/sp_unpack.sv
// Field decode and classification of one IEEE-754 single-precision operand.
module sp_unpack
    import sp_div_pkg::*;
(
    input  logic [31:0]   x,
    output logic          sign,
    output logic [EW-1:0] e,
    output logic [MW-1:0] m,
    output logic          is_zero,
    output logic          is_inf,
    output logic          is_nan
);

    logic [7:0]  ex;
    logic [22:0] fr;

    assign ex      = x[30:23];
    assign fr      = x[22:0];
    assign sign    = x[31];
    assign is_zero = (ex == 8'h00) && (fr == 23'd0);
    assign is_inf  = (ex == 8'hFF) && (fr == 23'd0);
    assign is_nan  = (ex == 8'hFF) && (fr != 23'd0);

    // Denormals sit at the minimum exponent without a hidden bit; normals get the hidden 1.
    always_comb begin
        if (ex == 8'h00) begin
            e = EMIN;
            m = {1'b0, fr};
        end else begin
            e = {2'b00, ex} - BIAS;
            m = {1'b1, fr};
        end
    end

endmodule

// File: rtl/sp_div_prenorm.sv
// Divider front end: captures operands on a strt edge, resolves special
// cases, and normalizes denormal mantissas one bit per cycle.
module sp_div_prenorm
    import sp_div_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          strt,
    input  logic [31:0]   a,
    input  logic [31:0]   b,
    output logic          o_strt,
    output logic          o_a_s,
    output logic          o_b_s,
    output logic [EW-1:0] o_a_e,
    output logic [EW-1:0] o_b_e,
    output logic [MW-1:0] o_a_m,
    output logic [MW-1:0] o_b_m,
    output logic          o_special,
    output logic [31:0]   o_special_z,
    output logic          o_busy
);

    state_t        state, nstate;
    logic          strt_q;
    logic [31:0]   a_r, b_r;
    logic [EW-1:0] ae, be, ae_nx, be_nx;
    logic [MW-1:0] am, bm, am_nx, bm_nx;
    logic          spec_nx;
    logic [31:0]   spz_nx;
    logic          cap, load, zs;

    logic          ua_s, ub_s;
    logic [EW-1:0] ua_e, ub_e;
    logic [MW-1:0] ua_m, ub_m;
    logic          ua_zero, ua_inf, ua_nan;
    logic          ub_zero, ub_inf, ub_nan;

    sp_unpack u_unpack_a (
        .x(a_r), .sign(ua_s), .e(ua_e), .m(ua_m),
        .is_zero(ua_zero), .is_inf(ua_inf), .is_nan(ua_nan)
    );

    sp_unpack u_unpack_b (
        .x(b_r), .sign(ub_s), .e(ub_e), .m(ub_m),
        .is_zero(ub_zero), .is_inf(ub_inf), .is_nan(ub_nan)
    );

    assign zs     = ua_s ^ ub_s;
    assign o_strt = (state == DONE);
    assign o_busy = (state != IDLE);
    // Outputs are refreshed only on the transition into DONE so they hold between results.
    assign load   = (state != DONE) && (nstate == DONE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nstate;
    end

    // Next state plus next values of the working operand registers.
    always_comb begin
        nstate  = state;
        ae_nx   = ae;
        be_nx   = be;
        am_nx   = am;
        bm_nx   = bm;
        spec_nx = 1'b0;
        spz_nx  = 32'd0;
        cap     = 1'b0;
        case (state)
            IDLE: begin
                if (strt && !strt_q) begin
                    cap    = 1'b1;
                    nstate = UNPACK;
                end
            end
            UNPACK: begin
                ae_nx = ua_e;
                be_nx = ub_e;
                am_nx = ua_m;
                bm_nx = ub_m;
                // Priority order matters: 0/0 and inf/inf must land on NaN first.
                if (ua_nan || ub_nan || (ua_zero && ub_zero) || (ua_inf && ub_inf)) begin
                    spec_nx = 1'b1;
                    spz_nx  = QNAN;
                end else if (ua_inf || ub_zero) begin
                    spec_nx = 1'b1;
                    spz_nx  = {zs, 8'hFF, 23'd0};
                end else if (ua_zero || ub_inf) begin
                    spec_nx = 1'b1;
                    spz_nx  = {zs, 31'd0};
                end
                if (spec_nx)                            nstate = DONE;
                else if (!ua_m[MW-1] || !ub_m[MW-1])    nstate = NORM;
                else                                    nstate = DONE;
            end
            NORM: begin
                // Zero operands never reach here, so the loop always terminates.
                if (!am[MW-1]) begin
                    am_nx = am << 1;
                    ae_nx = ae - EW'(1);
                end
                if (!bm[MW-1]) begin
                    bm_nx = bm << 1;
                    be_nx = be - EW'(1);
                end
                if (am_nx[MW-1] && bm_nx[MW-1]) nstate = DONE;
            end
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Edge detect, operand capture, working registers and held output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strt_q      <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            ae          <= '0;
            be          <= '0;
            am          <= '0;
            bm          <= '0;
            o_a_s       <= 1'b0;
            o_b_s       <= 1'b0;
            o_a_e       <= '0;
            o_b_e       <= '0;
            o_a_m       <= '0;
            o_b_m       <= '0;
            o_special   <= 1'b0;
            o_special_z <= '0;
        end else begin
            strt_q <= strt;
            if (cap) begin
                a_r <= a;
                b_r <= b;
            end
            ae <= ae_nx;
            be <= be_nx;
            am <= am_nx;
            bm <= bm_nx;
            if (load) begin
                o_a_s       <= ua_s;
                o_b_s       <= ub_s;
                o_a_e       <= ae_nx;
                o_b_e       <= be_nx;
                o_a_m       <= am_nx;
                o_b_m       <= bm_nx;
                o_special   <= spec_nx;
                o_special_z <= spz_nx;
            end
        end
    end

endmodule

// File: tb/tb_sp_div_prenorm.sv
// Directed self-checking bench for sp_div_prenorm.
module tb_sp_div_prenorm;

    logic        clk = 1'b0;
    logic        reset;
    logic        strt;
    logic [31:0] a, b;
    logic        o_strt, o_a_s, o_b_s, o_special, o_busy;
    logic [9:0]  o_a_e, o_b_e;
    logic [23:0] o_a_m, o_b_m;
    logic [31:0] o_special_z;

    int ncmp  = 0;
    int nfail = 0;
    int cnt;

    sp_div_prenorm dut (
        .clk(clk), .reset(reset), .strt(strt), .a(a), .b(b),
        .o_strt(o_strt), .o_a_s(o_a_s), .o_b_s(o_b_s),
        .o_a_e(o_a_e), .o_b_e(o_b_e), .o_a_m(o_a_m), .o_b_m(o_b_m),
        .o_special(o_special), .o_special_z(o_special_z), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ncmp++;
        assert (obs === exp_v)
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Drive operands with a strt edge; returns at the negedge after the capture edge.
    task automatic start_op(input logic [31:0] aa, input logic [31:0] bb);
        @(negedge clk);
        a    = aa;
        b    = bb;
        strt = 1'b1;
        @(negedge clk);
        strt = 1'b0;
    endtask

    // c0 negedges have passed since the one preceding the capture edge.
    task automatic wait_strt(input int c0, input int exp_lat, input string tag);
        int c;
        c = c0;
        while (!o_strt && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_lat"}, c, exp_lat);
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, o_strt}, 32'd0);
        chk({tag, "_idle"}, {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        strt  = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_strt", {31'd0, o_strt}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_am", {8'd0, o_a_m}, 32'd0);
        chk("rst_spz", o_special_z, 32'd0);
        reset = 1'b1;

        // 12.5 / 2.5: both normal, no normalization
        start_op(32'h4148_0000, 32'h4020_0000);
        chk("n0_busy", {31'd0, o_busy}, 32'd1);
        wait_strt(1, 2, "n0");
        chk("n0_ae", {22'd0, o_a_e}, 32'd3);
        chk("n0_am", {8'd0, o_a_m}, 32'h00C8_0000);
        chk("n0_be", {22'd0, o_b_e}, 32'd1);
        chk("n0_bm", {8'd0, o_b_m}, 32'h00A0_0000);
        chk("n0_spec", {31'd0, o_special}, 32'd0);
        chk("n0_sign", {30'd0, o_a_s, o_b_s}, 32'd0);

        // smallest denormal / 1.0: 23 normalization cycles
        start_op(32'h0000_0001, 32'h3F80_0000);
        wait_strt(1, 25, "dn");
        chk("dn_ae", {22'd0, o_a_e}, 32'h0000_036B);   // -149
        chk("dn_am", {8'd0, o_a_m}, 32'h0080_0000);
        chk("dn_be", {22'd0, o_b_e}, 32'd0);
        chk("dn_bm", {8'd0, o_b_m}, 32'h0080_0000);

        // special cases
        start_op(32'h3F80_0000, 32'h0000_0000);
        wait_strt(1, 2, "sp1");
        chk("sp1_spec", {31'd0, o_special}, 32'd1);
        chk("sp1_z", o_special_z, 32'h7F80_0000);

        start_op(32'h8000_0000, 32'h0000_0000);
        wait_strt(1, 2, "sp2");
        chk("sp2_spec", {31'd0, o_special}, 32'd1);
        chk("sp2_z", o_special_z, 32'h7FC0_0000);

        start_op(32'hC000_0000, 32'h7F80_0000);
        wait_strt(1, 2, "sp3");
        chk("sp3_z", o_special_z, 32'h8000_0000);

        // special cleared by a following normal op
        start_op(32'hC148_0000, 32'h4020_0000);
        wait_strt(1, 2, "n1");
        chk("n1_spec", {31'd0, o_special}, 32'd0);
        chk("n1_spz", o_special_z, 32'd0);
        chk("n1_sign", {30'd0, o_a_s, o_b_s}, 32'd2);

        // strt edge during NORM is ignored
        start_op(32'h0000_0001, 32'h3F80_0000);
        repeat (4) @(negedge clk);
        strt = 1'b1;
        wait_strt(5, 25, "ign");
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_strt) cnt++;
        end
        chk("ign_extra", cnt, 0);
        strt = 1'b0;
        start_op(32'h4148_0000, 32'h4020_0000);
        wait_strt(1, 2, "ign_next");
        chk("ign_next_am", {8'd0, o_a_m}, 32'h00C8_0000);

        // reset mid-NORM aborts the operation
        start_op(32'h0000_0001, 32'h3F80_0000);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ab_busy", {31'd0, o_busy}, 32'd0);
        chk("ab_strt", {31'd0, o_strt}, 32'd0);
        chk("ab_am", {8'd0, o_a_m}, 32'd0);
        chk("ab_ae", {22'd0, o_a_e}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_strt || o_busy) cnt++;
        end
        chk("ab_quiet", cnt, 0);

        // strt held high across reset release counts as an edge
        @(negedge clk);
        reset = 1'b0;
        a     = 32'h4020_0000;
        b     = 32'h4148_0000;
        strt  = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        wait_strt(0, 2, "rr");
        chk("rr_ae", {22'd0, o_a_e}, 32'd1);
        chk("rr_bm", {8'd0, o_b_m}, 32'h00C8_0000);
        strt = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
